// File: rtl/mem_wb_skid.sv
// rtl/mem_wb_skid.sv - MEM->WB pipeline stage with 2-entry skid buffer and flush
module mem_wb_skid #(
    parameter int LANES    = 1,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter bit ZERO_SUP = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*ADDR_W-1:0]   mem_wreg_addr,
    input  logic [LANES-1:0]          mem_wreg_enable,
    input  logic [LANES*DATA_W-1:0]   mem_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*ADDR_W-1:0]   wb_wreg_addr,
    output logic [LANES-1:0]          wb_wreg_enable,
    output logic [LANES*DATA_W-1:0]   wb_wdata
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Head entry drives the outputs; skid entry catches the beat that arrives
    // while the head is stalled.
    logic [LANES*ADDR_W-1:0] h_addr;
    logic [LANES-1:0]        h_en;
    logic [LANES*DATA_W-1:0] h_data;
    logic [LANES*ADDR_W-1:0] s_addr;
    logic [LANES-1:0]        s_en;
    logic [LANES*DATA_W-1:0] s_data;

    logic in_ready_q;
    logic accept;
    logic drain;
    logic load_h_in;
    logic load_h_skid;
    logic load_s;

    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    // Next-state and storage-load decode; flush overrides everything and
    // suppresses loads so the flushed beat never lands in storage.
    always_comb begin
        state_next  = state;
        load_h_in   = 1'b0;
        load_h_skid = 1'b0;
        load_s      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_h_in  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_h_in  = 1'b1;
                    state_next = ONE;
                end else if (accept) begin
                    load_s     = 1'b1;
                    state_next = FULL;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    load_h_skid = 1'b1;
                    state_next  = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        if (flush) begin
            state_next  = EMPTY;
            load_h_in   = 1'b0;
            load_h_skid = 1'b0;
            load_s      = 1'b0;
        end
    end

    // State register; in_ready is registered from the next state so it never
    // sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != FULL);
        end
    end

    // Head entry: load from input or promote from skid; otherwise frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_addr <= '0;
            h_en   <= '0;
            h_data <= '0;
        end else if (load_h_in) begin
            h_addr <= mem_wreg_addr;
            h_en   <= mem_wreg_enable;
            h_data <= mem_wdata;
        end else if (load_h_skid) begin
            h_addr <= s_addr;
            h_en   <= s_en;
            h_data <= s_data;
        end
    end

    // Skid entry: captures a beat accepted while the head is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_addr <= '0;
            s_en   <= '0;
            s_data <= '0;
        end else if (load_s) begin
            s_addr <= mem_wreg_addr;
            s_en   <= mem_wreg_enable;
            s_data <= mem_wdata;
        end
    end

    // Per-lane write enable: r0 suppression and higher-lane-wins on same address.
    always_comb begin
        logic [ADDR_W-1:0] addr_i;
        logic              keep;
        wb_wreg_enable = '0;
        addr_i         = '0;
        keep           = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            addr_i = h_addr[i*ADDR_W +: ADDR_W];
            keep   = out_valid & h_en[i];
            if (ZERO_SUP && (addr_i == '0)) begin
                keep = 1'b0;
            end
            for (int j = i + 1; j < LANES; j++) begin
                if (h_en[j] && (h_addr[j*ADDR_W +: ADDR_W] == addr_i)) begin
                    keep = 1'b0;
                end
            end
            wb_wreg_enable[i] = keep;
        end
    end

    assign wb_wreg_addr = h_addr;
    assign wb_wdata     = h_data;

endmodule
